// File: rtl/stamp2time_seq.sv
// stamp2time_seq: iterative Unix-seconds to BCD calendar converter.
// Define STAMP2TIME_12H_EN for 12-hour hour_bcd with a driven pm flag.
module stamp2time_seq #(
    parameter int STAMP_W     = 64,
    parameter int TZ_OFFSET_S = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [STAMP_W-1:0] stamp,
    output logic               busy,
    output logic               done,
    output logic               range_err,
    output logic [15:0]        year_bcd,
    output logic [7:0]         month_bcd,
    output logic [7:0]         day_bcd,
    output logic [7:0]         hour_bcd,
    output logic [7:0]         minute_bcd,
    output logic [7:0]         second_bcd,
    output logic [2:0]         weekday,
    output logic               pm
);

    typedef enum logic [2:0] {
        IDLE, ADJ, DIV_DAY, DIV_HOUR, DIV_MIN, YEAR, MONTH, OUT
    } state_e;

    localparam logic signed [STAMP_W+1:0] TZ_EXT =
        (STAMP_W+2)'(TZ_OFFSET_S);

    state_e               state_q;
    logic [STAMP_W-1:0]   div_n_q;
    logic [16:0]          div_r_q;
    logic [6:0]           cnt_q;
    logic [21:0]          days_q;
    logic [13:0]          year_q;
    logic [3:0]           month_q;
    logic [2:0]           wday_q;
    logic [4:0]           hour_q;
    logic [5:0]           min_q;
    logic [5:0]           sec_q;
    logic                 err_q;
    logic                 ovf_q;

    logic                 busy_q, done_q, rerr_q, pm_q;
    logic [15:0]          year_bcd_q;
    logic [7:0]           mon_bcd_q, day_bcd_q, hour_bcd_q;
    logic [7:0]           min_bcd_q, sec_bcd_q;
    logic [2:0]           wday_out_q;

    logic [17:0]          dvs, trial;
    logic                 ge;
    logic [16:0]          rem_nx;
    logic [STAMP_W-1:0]   quo_nx;
    logic signed [STAMP_W+1:0] adj;
    logic                 leap;
    logic [8:0]           ylen;
    logic [4:0]           mlen;
    logic [4:0]           hsrc, h_disp;
    logic                 pm_nx;
    logic [2:0]           wd_fin;

    function automatic logic [15:0] bcd4(input logic [13:0] b);
        logic [15:0] r;
        r = '0;
        for (int i = 13; i >= 0; i--) begin
            for (int d = 0; d < 4; d++)
                if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
            r = {r[14:0], b[i]};
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd2(input logic [6:0] v);
        return 8'({v / 7'd10, 4'h0}) | 8'(v % 7'd10);
    endfunction

    function automatic logic [2:0] wadd(input logic [2:0] w,
                                        input logic [2:0] k);
        logic [3:0] s;
        s = {1'b0, w} + {1'b0, k};
        return (s >= 4'd7) ? 3'(s - 4'd7) : 3'(s);
    endfunction

    always_comb begin
        case (state_q)
            DIV_DAY:  dvs = 18'd86400;
            DIV_HOUR: dvs = 18'd3600;
            default:  dvs = 18'd60;
        endcase
        trial  = {div_r_q, div_n_q[STAMP_W-1]};
        ge     = trial >= dvs;
        rem_nx = 17'(ge ? trial - dvs : trial);
        quo_nx = {div_n_q[STAMP_W-2:0], ge};
        adj    = $signed({2'b00, div_n_q}) + TZ_EXT;
        leap   = (year_q[1:0] == 2'd0) &&
                 ((year_q % 14'd100 != 14'd0) ||
                  (year_q % 14'd400 == 14'd0));
        ylen   = leap ? 9'd366 : 9'd365;
        case (month_q)
            4'd2:                    mlen = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: mlen = 5'd30;
            default:                 mlen = 5'd31;
        endcase
        hsrc = ovf_q ? 5'd23 : hour_q;
`ifdef STAMP2TIME_12H_EN
        if (hsrc == 5'd0)       h_disp = 5'd12;
        else if (hsrc > 5'd12)  h_disp = hsrc - 5'd12;
        else                    h_disp = hsrc;
        pm_nx = hsrc >= 5'd12;
`else
        h_disp = hsrc;
        pm_nx  = 1'b0;
`endif
        wd_fin = wadd(wday_q, 3'(days_q[4:0] % 5'd7));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            div_n_q    <= '0;
            div_r_q    <= '0;
            cnt_q      <= '0;
            days_q     <= '0;
            year_q     <= 14'd1970;
            month_q    <= 4'd1;
            wday_q     <= 3'd4;
            hour_q     <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rerr_q     <= 1'b0;
            pm_q       <= 1'b0;
            year_bcd_q <= 16'h1970;
            mon_bcd_q  <= 8'h01;
            day_bcd_q  <= 8'h01;
            hour_bcd_q <= 8'h00;
            min_bcd_q  <= 8'h00;
            sec_bcd_q  <= 8'h00;
            wday_out_q <= 3'd4;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    div_n_q <= stamp;
                    err_q   <= 1'b0;
                    ovf_q   <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= ADJ;
                end
                ADJ: begin
                    div_r_q <= '0;
                    cnt_q   <= 7'(STAMP_W - 1);
                    state_q <= DIV_DAY;
                    if (adj[STAMP_W+1]) begin
                        div_n_q <= '0;
                        err_q   <= 1'b1;
                    end else if (adj[STAMP_W]) begin
                        div_n_q <= '1;
                        err_q   <= 1'b1;
                    end else begin
                        div_n_q <= adj[STAMP_W-1:0];
                    end
                end
                DIV_DAY: begin
                    cnt_q <= cnt_q - 7'd1;
                    if (cnt_q == 7'd0) begin
                        days_q  <= 22'(quo_nx);
                        ovf_q   <= quo_nx >
                            {{(STAMP_W-22){1'b0}}, 22'd2932896};
                        div_n_q <= {rem_nx, {(STAMP_W-17){1'b0}}};
                        div_r_q <= '0;
                        cnt_q   <= 7'd16;
                        state_q <= DIV_HOUR;
                    end else begin
                        div_n_q <= quo_nx;
                        div_r_q <= rem_nx;
                    end
                end
                DIV_HOUR: begin
                    cnt_q <= cnt_q - 7'd1;
                    if (cnt_q == 7'd0) begin
                        hour_q  <= 5'(quo_nx);
                        div_n_q <= {rem_nx[11:0], {(STAMP_W-12){1'b0}}};
                        div_r_q <= '0;
                        cnt_q   <= 7'd11;
                        state_q <= DIV_MIN;
                    end else begin
                        div_n_q <= quo_nx;
                        div_r_q <= rem_nx;
                    end
                end
                DIV_MIN: begin
                    cnt_q <= cnt_q - 7'd1;
                    if (cnt_q == 7'd0) begin
                        min_q <= 6'(quo_nx);
                        sec_q <= 6'(rem_nx);
                        if (ovf_q) begin
                            // past 9999-12-31: pin to the last representable second
                            year_bcd_q <= 16'h9999;
                            mon_bcd_q  <= 8'h12;
                            day_bcd_q  <= 8'h31;
                            hour_bcd_q <= bcd2({2'b00, h_disp});
                            min_bcd_q  <= 8'h59;
                            sec_bcd_q  <= 8'h59;
                            wday_out_q <= 3'd5;
                            pm_q       <= pm_nx;
                            rerr_q     <= 1'b1;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= OUT;
                        end else begin
                            year_q  <= 14'd1970;
                            wday_q  <= 3'd4;
                            state_q <= YEAR;
                        end
                    end else begin
                        div_n_q <= quo_nx;
                        div_r_q <= rem_nx;
                    end
                end
                YEAR: begin
                    if (days_q >= {13'd0, ylen}) begin
                        days_q <= days_q - {13'd0, ylen};
                        year_q <= year_q + 14'd1;
                        wday_q <= wadd(wday_q, leap ? 3'd2 : 3'd1);
                    end else begin
                        month_q <= 4'd1;
                        state_q <= MONTH;
                    end
                end
                MONTH: begin
                    if (days_q >= {17'd0, mlen}) begin
                        days_q  <= days_q - {17'd0, mlen};
                        month_q <= month_q + 4'd1;
                        wday_q  <= wadd(wday_q, 3'(mlen - 5'd28));
                    end else begin
                        year_bcd_q <= bcd4(year_q);
                        mon_bcd_q  <= bcd2({3'b000, month_q});
                        day_bcd_q  <= bcd2({2'b00, days_q[4:0] + 5'd1});
                        hour_bcd_q <= bcd2({2'b00, h_disp});
                        min_bcd_q  <= bcd2({1'b0, min_q});
                        sec_bcd_q  <= bcd2({1'b0, sec_q});
                        wday_out_q <= wd_fin;
                        pm_q       <= pm_nx;
                        rerr_q     <= err_q;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= OUT;
                    end
                end
                OUT: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign range_err  = rerr_q;
    assign year_bcd   = year_bcd_q;
    assign month_bcd  = mon_bcd_q;
    assign day_bcd    = day_bcd_q;
    assign hour_bcd   = hour_bcd_q;
    assign minute_bcd = min_bcd_q;
    assign second_bcd = sec_bcd_q;
    assign weekday    = wday_out_q;
    assign pm         = pm_q;

endmodule

// File: tb/tb_stamp2time_seq.sv
// tb_stamp2time_seq: three converters (TZ 0, +28800, -3600) against a
// calendar reference model; directed corner stamps plus random ones.
module tb_stamp2time_seq;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start      [3];
    logic [63:0] stamp      [3];
    logic        busy       [3];
    logic        done       [3];
    logic        range_err  [3];
    logic        pm         [3];
    logic [15:0] year_bcd   [3];
    logic [7:0]  month_bcd  [3];
    logic [7:0]  day_bcd    [3];
    logic [7:0]  hour_bcd   [3];
    logic [7:0]  minute_bcd [3];
    logic [7:0]  second_bcd [3];
    logic [2:0]  weekday    [3];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int TZ = (g == 0) ? 0 : ((g == 1) ? 28800 : -3600);
        stamp2time_seq #(.STAMP_W(64), .TZ_OFFSET_S(TZ)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start[g]), .stamp(stamp[g]),
            .busy(busy[g]), .done(done[g]), .range_err(range_err[g]),
            .year_bcd(year_bcd[g]), .month_bcd(month_bcd[g]),
            .day_bcd(day_bcd[g]), .hour_bcd(hour_bcd[g]),
            .minute_bcd(minute_bcd[g]), .second_bcd(second_bcd[g]),
            .weekday(weekday[g]), .pm(pm[g])
        );
    end

    typedef struct {
        logic [15:0] y;
        logic [7:0]  mo, d, h, mi, s;
        logic [2:0]  wd;
        logic        pm, err;
        int          lat;
    } exp_t;

    function automatic int tz_of(int k);
        return (k == 0) ? 0 : ((k == 1) ? 28800 : -3600);
    endfunction

    function automatic int ylen(int y);
        return (((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0)) ? 366 : 365;
    endfunction

    function automatic int mlen(int y, int m);
        int t [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m == 2 && ylen(y) == 366) return 29;
        return t[m-1];
    endfunction

    function automatic logic [15:0] bcd(int v);
        return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 +
                   ((v / 10) % 10) * 16 + v % 10);
    endfunction

    function automatic exp_t model(logic [63:0] st, int tz);
        exp_t e;
        logic [63:0] a;
        longint unsigned days, rem, d;
        int y, m, hh, h12;
        e.err = 1'b0;
        if (tz < 0 && st < 64'(-tz)) begin
            a = 64'd0;
            e.err = 1'b1;
        end else if (tz > 0 && st > 64'hFFFF_FFFF_FFFF_FFFF - 64'(tz)) begin
            a = 64'hFFFF_FFFF_FFFF_FFFF;
            e.err = 1'b1;
        end else begin
            a = st + 64'(tz);
        end
        days = a / 86400;
        rem  = a % 86400;
        if (days > 2932896) begin
            e.y = 16'h9999; e.mo = 8'h12; e.d = 8'h31;
            e.mi = 8'h59; e.s = 8'h59; e.wd = 3'd5;
            e.err = 1'b1; e.lat = 95; hh = 23;
        end else begin
            y = 1970;
            d = days;
            while (d >= longint'(ylen(y))) begin d -= ylen(y); y++; end
            m = 1;
            while (d >= longint'(mlen(y, m))) begin d -= mlen(y, m); m++; end
            e.y   = bcd(y);
            e.mo  = 8'(bcd(m));
            e.d   = 8'(bcd(int'(d) + 1));
            e.wd  = 3'((days + 4) % 7);
            e.mi  = 8'(bcd(int'((rem % 3600) / 60)));
            e.s   = 8'(bcd(int'(rem % 60)));
            e.lat = 96 + (y - 1970) + m;
            hh    = int'(rem / 3600);
        end
`ifdef STAMP2TIME_12H_EN
        h12  = (hh % 12 == 0) ? 12 : hh % 12;
        e.h  = 8'(bcd(h12));
        e.pm = hh >= 12;
`else
        h12  = hh;
        e.h  = 8'(bcd(h12));
        e.pm = 1'b0;
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] snap(int k);
        return {year_bcd[k], month_bcd[k], day_bcd[k], hour_bcd[k],
                minute_bcd[k], second_bcd[k]};
    endfunction

    task automatic chk_rst(input int k);
        chk("rst_fields", snap(k), 64'h0019_7001_0100_0000);
        chk("rst_flags", {weekday[k], pm[k], range_err[k], busy[k], done[k]},
            7'b100_0000);
    endtask

    task automatic run(input int k, input logic [63:0] st, input int hold);
        exp_t e;
        int n, extra;
        bit busy_ok, hold_ok;
        logic [63:0] prev;
        e = model(st, tz_of(k));
        @(negedge clk);
        stamp[k] = st;
        start[k] = 1'b1;
        prev = snap(k);
        @(negedge clk);
        n = 1;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (done[k] !== 1'b1 && n < 20000) begin
            if (busy[k] !== 1'b1) busy_ok = 1'b0;
            if (snap(k) !== prev) hold_ok = 1'b0;
            if (n >= hold) start[k] = 1'b0;
            @(negedge clk);
            n++;
        end
        start[k] = 1'b0;
        if (done[k] !== 1'b1) begin
            chk("timeout", 64'd0, 64'd1);
            return;
        end
        chk("latency", 64'(n), 64'(e.lat));
        chk("busy", {busy_ok, busy[k]}, 2'b10);
        chk("hold", hold_ok, 1'b1);
        chk("year", year_bcd[k], e.y);
        chk("month", month_bcd[k], e.mo);
        chk("day", day_bcd[k], e.d);
        chk("hour", hour_bcd[k], e.h);
        chk("minute", minute_bcd[k], e.mi);
        chk("second", second_bcd[k], e.s);
        chk("weekday", weekday[k], e.wd);
        chk("pm", pm[k], e.pm);
        chk("range_err", range_err[k], e.err);
        @(negedge clk);
        chk("done_pulse", {done[k], busy[k]}, 2'b00);
        chk("stable", {year_bcd[k], day_bcd[k], second_bcd[k]},
            {e.y, e.d, e.s});
        if (hold > 1) begin
            extra = 0;
            repeat (150) begin
                @(negedge clk);
                if (done[k] === 1'b1) extra++;
            end
            chk("one_done", 64'(extra), 64'd0);
        end
    endtask

    initial begin
        int k, r;
        logic [63:0] st;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            stamp[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk_rst(0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_rst(1);

        run(0, 64'd0, 0);
        run(0, 64'd951782400, 0);
        run(0, 64'd4107542400, 0);
        run(0, 64'd1 << 40, 0);
        run(0, 64'd253402300799, 0);
        run(0, 64'd253402300800, 0);
        run(0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run(0, 64'd43200, 0);
        run(1, 64'd1700000000, 0);
        run(1, 64'hFFFF_FFFF_FFFF_FF00, 0);
        run(2, 64'd100, 0);
        run(2, 64'd3599, 0);
        run(2, 64'd3600, 0);
        run(0, 64'd1700000000, 30);

        @(negedge clk);
        stamp[0] = 64'd1234567;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (20) @(negedge clk);
        chk("busy_mid", busy[0], 1'b1);
        rst_n = 1'b0;
        #1;
        chk_rst(0);
        @(negedge clk);
        rst_n = 1'b1;
        r = 0;
        repeat (150) begin
            @(negedge clk);
            if (done[0] === 1'b1 || busy[0] === 1'b1) r++;
        end
        chk("no_done_after_rst", 64'(r), 64'd0);

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 2);
            r = $urandom_range(0, 9);
            if (r < 6)      st = {32'd0, $urandom};
            else if (r < 8) st = {$urandom, $urandom};
            else            st = 64'($urandom_range(0, 200000));
            run(k, st, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stamp2time_seq.md
# stamp2time_seq

Sequential, parametrised Unix-timestamp-to-calendar converter; successor to the combinational timestamp decoder in the display path. It accepts a STAMP_W-bit Unix time with a start/done handshake and applies a compile-time timezone offset. It resolves the date iteratively with one shared restoring divider, year/month walkers and a weekday tracker. Outputs are registered BCD fields plus weekday, feeding the display multiplexer.

## Interface
- STAMP_W, 64, timestamp width in bits; legal range 32..64
- TZ_OFFSET_S, 0, signed timezone offset in seconds, added to the stamp; legal range −43200..+50400
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request conversion; sampled only in IDLE
- stamp  in  STAMP_W  unsigned Unix seconds; captured when start is accepted
- busy  out  1  high from the cycle after accept until done
- done  out  1  one-cycle pulse; result fields valid and stable from this cycle on
- range_err  out  1  last result was clamped or saturated; updated with done
- year_bcd  out  16  four BCD digits
- month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd  out  8 each  two BCD digits
- weekday  out  3  0 = Sunday .. 6 = Saturday
- pm  out  1  PM flag in 12-hour mode; otherwise 0

## Operation
- States: IDLE, ADJ, DIV_DAY, DIV_HOUR, DIV_MIN, YEAR, MONTH, OUT.
- IDLE: start=1 captures stamp and moves to ADJ. start in any other state is ignored and does not queue.
- ADJ: a = stamp + TZ_OFFSET_S, computed signed at STAMP_W+2 bits.
  - If a < 0: a = 0 and err = 1.
  - If a ≥ 2^STAMP_W: saturate (see overflow below).
- DIV_DAY: restoring division a / 86400, one quotient bit per cycle, STAMP_W cycles. Produces days and a 17-bit remainder.
- Overflow: if days > 2932896 (9999-12-31), the result is 9999-12-31 23:59:59, weekday 5, err = 1, and the FSM goes straight to OUT.
- DIV_HOUR: remainder / 3600, 17 cycles.
- DIV_MIN: remainder / 60, 12 cycles. The final remainder is the seconds value.
- YEAR: year starts at 1970, weekday at 4.
  - Each cycle compares days with len = 365 + leap(year); leap = div4 && (!div100 || div400).
  - If days ≥ len: days −= len, year++, weekday += len mod 7 (mod 7). Otherwise go to MONTH.
- MONTH: same walk over month lengths; February is 29 in leap years. Exits when days < length.
- OUT: day = days + 1; weekday = (weekday + days) mod 7. All fields are converted to BCD and registered. done pulses, then IDLE.
- Reset values: year 0x1970, month 0x01, day 0x01, hour/minute/second 0x00, weekday 4, pm 0, range_err 0, busy 0, done 0. State is IDLE.
- Reset mid-operation aborts immediately: outputs return to reset values and no done is produced.

## Timing
- Accept edge = cycle 0. done is high in cycle L.
- Normal: L = STAMP_W + 32 + Y + M, where Y = year − 1970 and M = month (1..12).
- Overflow: L = STAMP_W + 31.
- busy is high in cycles 1..L−1. busy and done are never high together.
- The earliest next accept is cycle L+1, when the FSM is back in IDLE.
- Result outputs change only in the done cycle or on reset.

## Configuration
- STAMP2TIME_12H_EN defined: hour_bcd is 12-hour format and pm is driven.
  - hour 0 → 0x12, pm 0; 1..11 → unchanged, pm 0; 12 → 0x12, pm 1; 13..23 → hour−12, pm 1.
  - Saturated overflow output is 0x11, pm 1.
- Undefined: hour_bcd is 0x00..0x23 and pm is tied 0.
- Latency is identical in both builds.

## Test plan
- STAMP_W 64, TZ 0, stamp 0 → 1970-01-01 00:00:00, weekday 4, range_err 0, done at cycle 97.
- stamp 951782400 → 2000-02-29 00:00:00, weekday 2, done at cycle 128. stamp 4107542400 → 2100-03-01, confirming 2100 is not leap.
- TZ_OFFSET_S 28800, stamp 1700000000 → 2023-11-15 06:13:20, weekday 3. With TZ_OFFSET_S −3600, stamp 100 → epoch output with range_err 1.
- stamp 2^40 → 9999-12-31 23:59:59, weekday 5, range_err 1, done at cycle 95.
- Reset pulsed in DIV_DAY → busy 0, epoch outputs, no done. start asserted while busy → ignored, exactly one done.
- STAMP2TIME_12H_EN, stamp 1700000000, TZ 0 → hour_bcd 0x10, pm 1. Stamp 43200 → 0x12, pm 1. Stamp 0 → 0x12, pm 0.
